// File: rtl/det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : det_pkg
// Description : Shared definitions for the det_nxn determinant engine:
//               default geometry, one-hot state encoding and the helper that
//               maps (row, col) to a flat element index in mat_flat.
// Revision    : 1.0 - initial release
// ============================================================================
package det_pkg;

    localparam int DET_N_DEF  = 8;
    localparam int DET_EW_DEF = 4;
    localparam int DET_DW_DEF = 48;

    // One-hot state encoding, MSB first: {DONE,DIV,ELIM,PIVOT,LOAD,IDLE}
    localparam logic [5:0] ST_IDLE  = 6'b000001;
    localparam logic [5:0] ST_LOAD  = 6'b000010;
    localparam logic [5:0] ST_PIVOT = 6'b000100;
    localparam logic [5:0] ST_ELIM  = 6'b001000;
    localparam logic [5:0] ST_DIV   = 6'b010000;
    localparam logic [5:0] ST_DONE  = 6'b100000;

    typedef enum logic [5:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_PIVOT = ST_PIVOT,
        S_ELIM  = ST_ELIM,
        S_DIV   = ST_DIV,
        S_DONE  = ST_DONE
    } state_t;

    // Row-major flat index with a fixed stride of n, independent of the
    // active dimension.
    function automatic int flat_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/det_sdiv.sv
`default_nettype none
// ============================================================================
// Module      : det_sdiv
// Description : Signed restoring divider. 2*DW-bit dividend, DW-bit divisor,
//               one quotient bit per cycle. A start pulse latches operands;
//               done is raised 2*DW cycles later for one cycle with the
//               signed quotient, so the result is consumed 2*DW+1 cycles
//               after start. Remainder is discarded (callers use exact
//               division only).
// Ports       : Clk, Reset (async, active-high), start, dividend, divisor,
//               done, quotient
// Revision    : 1.0 - initial release
// ============================================================================
module det_sdiv
    import det_pkg::*;
#(
    parameter int DW = DET_DW_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            done,
    output logic [2*DW-1:0] quotient
);

    localparam int PW = 2 * DW;
    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] C_LAST = CW'(PW);

    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] dvd_q, dvd_d;   // dividend magnitude, quotient shifts in at LSB
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic          neg_q, neg_d;

    logic [DW:0]   rem_sh;
    logic [DW+1:0] diff;

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        neg_d  = neg_q;
        rem_sh = {rem_q, dvd_q[PW-1]};
        // Extra top bit acts as the borrow: set means rem_sh < divisor.
        diff   = {1'b0, rem_sh} - {2'b00, dvs_q};

        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            rem_d = '0;
            dvd_d = dividend[PW-1] ? (~dividend + 1'b1) : dividend;
            dvs_d = divisor[DW-1]  ? (~divisor + 1'b1)  : divisor;
            neg_d = dividend[PW-1] ^ divisor[DW-1];
        end else if (run_q) begin
            if (cnt_q == C_LAST) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (!diff[DW+1]) begin
                    rem_d = diff[DW-1:0];
                    dvd_d = {dvd_q[PW-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[DW-1:0];
                    dvd_d = {dvd_q[PW-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            dvd_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            neg_q <= 1'b0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            neg_q <= neg_d;
        end
    end

    assign done     = run_q && (cnt_q == C_LAST);
    assign quotient = neg_q ? (~dvd_q + 1'b1) : dvd_q;

endmodule
`default_nettype wire

// File: rtl/det_nxn.sv
`default_nettype none
// ============================================================================
// Module      : det_nxn
// Description : Exact integer determinant of the top-left size x size block of
//               an N x N matrix using fraction-free Bareiss elimination with
//               row pivoting. One (i,j) update per cycle; steps after the
//               first divide exactly by the previous pivot via det_sdiv.
// Ports       : Clk, Reset (async, active-high)
//               Start/size/mat_flat  - request, sampled in IDLE
//               Ack                  - result acknowledge, sampled in DONE
//               det, done            - result, valid while done=1
//               busy, singular, ovf, err, state_q - status
// Config      : DETN_SIGNED_EN defined   -> elements are two's complement
//               DETN_SIGNED_EN undefined -> elements are unsigned
// Revision    : 1.0 - initial release
// ============================================================================
module det_nxn
    import det_pkg::*;
#(
    parameter int N  = DET_N_DEF,
    parameter int EW = DET_EW_DEF,
    parameter int DW = DET_DW_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Ack,
    input  logic [3:0]        size,
    input  logic [N*N*EW-1:0] mat_flat,
    output logic [DW-1:0]     det,
    output logic              busy,
    output logic              done,
    output logic              singular,
    output logic              ovf,
    output logic              err,
    output logic [5:0]        state_q
);

    localparam int PW = 2 * DW;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] C_N = 4'(N);

    typedef logic [N-1:0][DW-1:0] row_t;

    state_t        st_q, st_d;
    logic [3:0]    size_q, size_d;
    logic [3:0]    k_q, k_d;
    logic [3:0]    i_q, i_d;
    logic [3:0]    j_q, j_d;
    logic [3:0]    r_q, r_d;
    logic          sign_neg_q, sign_neg_d;
    logic [DW-1:0] prev_q, prev_d;
    logic [DW-1:0] det_q, det_d;
    logic          singular_q, singular_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    row_t          m_q [N];
    row_t          m_d [N];
    row_t          ld_val [N];

    function automatic logic [DW-1:0] ext_el(input logic [EW-1:0] e);
`ifdef DETN_SIGNED_EN
        return {{(DW-EW){e[EW-1]}}, e};
`else
        return {{(DW-EW){1'b0}}, e};
`endif
    endfunction

    function automatic logic signed [PW-1:0] sx2(input logic [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    // Widened copy of every element, ready for the single LOAD cycle.
    for (genvar gr = 0; gr < N; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            localparam int FI = flat_idx(gr, gc, N);
            assign ld_val[gr][gc] = ext_el(mat_flat[FI*EW +: EW]);
        end
    end

    logic [IW-1:0] k_idx, i_idx, j_idx, r_idx, l_idx;
    assign k_idx = k_q[IW-1:0];
    assign i_idx = i_q[IW-1:0];
    assign j_idx = j_q[IW-1:0];
    assign r_idx = r_q[IW-1:0];
    assign l_idx = IW'(size_q - 4'd1);

    // Bareiss numerator for the current (i,j) at double width.
    logic signed [PW-1:0] num;
    assign num = sx2(m_q[k_idx][k_idx]) * sx2(m_q[i_idx][j_idx])
               - sx2(m_q[i_idx][k_idx]) * sx2(m_q[k_idx][j_idx]);

    logic          div_start, div_done;
    logic [PW-1:0] div_q;

    det_sdiv #(.DW(DW)) u_div (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (div_start),
        .dividend (num),
        .divisor  (prev_q),
        .done     (div_done),
        .quotient (div_q)
    );

    logic              adv;
    logic [PW-1:0]     wr_val;
    logic              wr_fits;
    logic signed [DW:0] wv_ext, det_full;

    assign wr_fits  = (wr_val[PW-1:DW-1] == {(DW+1){wr_val[DW-1]}});
    assign wv_ext   = {wr_val[DW-1], wr_val[DW-1:0]};
    assign det_full = sign_neg_q ? -wv_ext : wv_ext;

    always_comb begin
        st_d       = st_q;
        size_d     = size_q;
        k_d        = k_q;
        i_d        = i_q;
        j_d        = j_q;
        r_d        = r_q;
        sign_neg_d = sign_neg_q;
        prev_d     = prev_q;
        det_d      = det_q;
        singular_d = singular_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        m_d        = m_q;
        div_start  = 1'b0;
        adv        = 1'b0;
        wr_val     = '0;

        case (st_q)
            S_IDLE: begin
                if (Start) begin
                    singular_d = 1'b0;
                    ovf_d      = 1'b0;
                    err_d      = 1'b0;
                    det_d      = '0;
                    size_d     = size;
                    if (size == 4'd0 || size > C_N) begin
                        err_d = 1'b1;
                        st_d  = S_DONE;
                    end else begin
                        st_d  = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                m_d        = ld_val;
                sign_neg_d = 1'b0;
                prev_d     = DW'(1);
                k_d        = 4'd0;
                r_d        = 4'd1;
                if (size_q == 4'd1) begin
                    det_d = ld_val[0][0];
                    st_d  = S_DONE;
                end else begin
                    st_d  = S_PIVOT;
                end
            end

            S_PIVOT: begin
                if (m_q[k_idx][k_idx] != '0) begin
                    i_d  = k_q + 4'd1;
                    j_d  = k_q + 4'd1;
                    st_d = S_ELIM;
                end else if (m_q[r_idx][k_idx] != '0) begin
                    // Whole-row swap; columns left of k are dead anyway.
                    m_d[k_idx] = m_q[r_idx];
                    m_d[r_idx] = m_q[k_idx];
                    sign_neg_d = ~sign_neg_q;
                    i_d        = k_q + 4'd1;
                    j_d        = k_q + 4'd1;
                    st_d       = S_ELIM;
                end else if (r_q == size_q - 4'd1) begin
                    singular_d = 1'b1;
                    det_d      = '0;
                    st_d       = S_DONE;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end

            S_ELIM: begin
                if (k_q == 4'd0) begin
                    // prev is 1 on the first step: no division needed.
                    adv    = 1'b1;
                    wr_val = num;
                end else begin
                    div_start = 1'b1;
                    st_d      = S_DIV;
                end
            end

            S_DIV: begin
                if (div_done) begin
                    adv    = 1'b1;
                    wr_val = div_q;
                    st_d   = S_ELIM;
                end
            end

            S_DONE: begin
                if (Ack) begin
                    st_d = S_IDLE;
                end
            end

            default: begin
                st_d = S_IDLE;
            end
        endcase

        if (adv) begin
            m_d[i_idx][j_idx] = wr_val[DW-1:0];
            if (!wr_fits) begin
                ovf_d = 1'b1;
            end
            if (j_q != size_q - 4'd1) begin
                j_d = j_q + 4'd1;
            end else if (i_q != size_q - 4'd1) begin
                i_d = i_q + 4'd1;
                j_d = k_q + 4'd1;
            end else begin
                // Last pair of this step: the value just written is the
                // bottom-right element, which is the determinant on the
                // final step.
                prev_d = m_q[k_idx][k_idx];
                k_d    = k_q + 4'd1;
                r_d    = k_q + 4'd2;
                if (k_q + 4'd1 == size_q - 4'd1) begin
                    det_d = det_full[DW-1:0];
                    if (det_full[DW] != det_full[DW-1]) begin
                        ovf_d = 1'b1;
                    end
                    st_d = S_DONE;
                end else begin
                    st_d = S_PIVOT;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            st_q       <= S_IDLE;
            size_q     <= '0;
            k_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            r_q        <= '0;
            sign_neg_q <= 1'b0;
            prev_q     <= '0;
            det_q      <= '0;
            singular_q <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            size_q     <= size_d;
            k_q        <= k_d;
            i_q        <= i_d;
            j_q        <= j_d;
            r_q        <= r_d;
            sign_neg_q <= sign_neg_d;
            prev_q     <= prev_d;
            det_q      <= det_d;
            singular_q <= singular_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    // Working array carries no reset: it is always reloaded before use.
    always_ff @(posedge Clk) begin
        m_q <= m_d;
    end

    assign state_q  = st_q;
    assign busy     = (st_q == S_LOAD) || (st_q == S_PIVOT) ||
                      (st_q == S_ELIM) || (st_q == S_DIV);
    assign done     = (st_q == S_DONE);
    assign det      = det_q;
    assign singular = singular_q;
    assign ovf      = ovf_q;
    assign err      = err_q;

    // Lint-only sink for the wrapped index of the last row.
    logic unused_l;
    assign unused_l = ^l_idx;

endmodule
`default_nettype wire

// File: tb/tb_det_nxn.sv
`default_nettype none
// ============================================================================
// Module      : tb_det_nxn
// Description : Self-checking bench for det_nxn. Expected results come from a
//               permutation-sum determinant model; a monitor pops them from a
//               scoreboard whenever done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_det_nxn;

    localparam int N  = 8;
    localparam int EW = 4;
    localparam int DW = 48;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic              Ack = 1'b0;
    logic [3:0]        size = 4'd0;
    logic [N*N*EW-1:0] mat_flat = '0;
    logic [DW-1:0]     det;
    logic              busy, done, singular, ovf, err;
    logic [5:0]        state_q;

    det_nxn #(.N(N), .EW(EW), .DW(DW)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Ack      (Ack),
        .size     (size),
        .mat_flat (mat_flat),
        .det      (det),
        .busy     (busy),
        .done     (done),
        .singular (singular),
        .ovf      (ovf),
        .err      (err),
        .state_q  (state_q)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [DW-1:0] det;
        logic          sing;
        logic          ovf;
        logic          err;
    } exp_t;

    exp_t   sb[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     matv [8][8];
    longint a    [8][8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Determinant of rows rl[0..n-1] x columns 0..n-1 of a[][] as the signed
    // sum over all permutations, enumerated in lexicographic order.
    function automatic longint perm_det(input int n, input int rl[8]);
        int     p[8];
        int     x, y, lo, hi, tmp, sgn;
        longint total, term;
        bit     more;
        for (int q = 0; q < 8; q++) p[q] = q;
        total = 0;
        sgn   = 1;
        more  = 1'b1;
        while (more) begin
            term = longint'(sgn);
            for (int q = 0; q < n; q++) term = term * a[rl[q]][p[q]];
            total = total + term;
            x = n - 2;
            while (x >= 0 && p[x] >= p[x+1]) x--;
            if (x < 0) begin
                more = 1'b0;
            end else begin
                y = n - 1;
                while (p[y] <= p[x]) y--;
                tmp = p[x]; p[x] = p[y]; p[y] = tmp; sgn = -sgn;
                lo = x + 1; hi = n - 1;
                while (lo < hi) begin
                    tmp = p[lo]; p[lo] = p[hi]; p[hi] = tmp; sgn = -sgn;
                    lo++; hi--;
                end
            end
        end
        return total;
    endfunction

    task automatic model(input int sz, output exp_t e);
        int     rl[8];
        int     rl2[8];
        int     w;
        bit     full;
        longint d;
        logic [63:0] dl;
        e.det = '0; e.sing = 1'b0; e.ovf = 1'b0; e.err = 1'b0;
        if (sz == 0 || sz > N) begin
            e.err = 1'b1;
            return;
        end
        for (int r = 0; r < 8; r++) begin
            rl[r] = r;
            for (int c = 0; c < 8; c++) begin
`ifdef DETN_SIGNED_EN
                a[r][c] = (matv[r][c] >= 8) ? longint'(matv[r][c] - 16) : longint'(matv[r][c]);
`else
                a[r][c] = longint'(matv[r][c]);
`endif
            end
        end
        d = perm_det(sz, rl);
        // Pivot search only fails if the first sz-1 columns are dependent,
        // i.e. every (sz-1)x(sz-1) minor on those columns vanishes.
        if (d == 0 && sz > 1) begin
            full = 1'b0;
            for (int ex = 0; ex < sz; ex++) begin
                w = 0;
                for (int r = 0; r < 8; r++) begin
                    rl2[r] = 0;
                end
                for (int r = 0; r < sz; r++) begin
                    if (r != ex) begin
                        rl2[w] = r;
                        w++;
                    end
                end
                if (perm_det(sz - 1, rl2) != 0) full = 1'b1;
            end
            e.sing = ~full;
        end
        dl = d;
        e.det = dl[DW-1:0];
    endtask

    task automatic fill_rand(input int maxv);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                matv[r][c] = int'($urandom_range(0, maxv));
    endtask

    task automatic set_identity(input int sz);
        fill_rand(15);
        for (int r = 0; r < sz; r++)
            for (int c = 0; c < sz; c++)
                matv[r][c] = (r == c) ? 1 : 0;
    endtask

    task automatic drive_mat();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat_flat[(r*N+c)*EW +: EW] = matv[r][c][EW-1:0];
    endtask

    // Monitor: one scoreboard entry per rising edge of done.
    initial begin
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge Clk);
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected no pending result");
                end else begin
                    e = sb.pop_front();
                    check("det", 64'(det), 64'(e.det));
                    check("singular", 64'(singular), 64'(e.sing));
                    check("ovf", 64'(ovf), 64'(e.ovf));
                    check("err", 64'(err), 64'(e.err));
                end
            end
            prev_done = done;
        end
    end

    task automatic run_op(input int sz, input bit poke);
        exp_t e;
        int   t;
        model(sz, e);
        sb.push_back(e);
        drive_mat();
        size  = 4'(sz);
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        if (poke) begin
            check("busy_after_start", 64'(busy), 64'(1));
            repeat (3) @(posedge Clk);
            #1;
            size  = 4'd9;
            Start = 1'b1;
            @(posedge Clk); #1;
            Start = 1'b0;
        end
        t = 0;
        while (!done && t < 30000) begin
            @(negedge Clk);
            t++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got no done after %0d cycles, expected done", t);
            $fatal(1, "stopping on timeout");
        end
        if (poke) begin
            repeat (20) begin
                @(negedge Clk);
                check("det_hold", 64'(det), 64'(e.det));
                check("done_hold", 64'(done), 64'(1));
            end
        end
        @(posedge Clk); #1;
        Ack = 1'b1;
        @(posedge Clk); #1;
        Ack = 1'b0;
        check("idle_after_ack", 64'(state_q), 64'(6'b000001));
        if (poke) begin
            repeat (5) @(negedge Clk);
            check("stay_idle", 64'(state_q), 64'(6'b000001));
            @(posedge Clk); #1;
        end
    endtask

    task automatic reset_in_div();
        exp_t e;
        int   t;
        set_identity(4);
        model(4, e);
        sb.push_back(e);
        drive_mat();
        size  = 4'd4;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        t = 0;
        while (state_q != 6'b010000 && t < 5000) begin
            @(negedge Clk);
            t++;
        end
        check("reach_div", 64'(state_q), 64'(6'b010000));
        #2;
        Reset = 1'b1;
        #1;
        check("rst_state", 64'(state_q), 64'(6'b000001));
        check("rst_det", 64'(det), 64'(0));
        check("rst_flags", 64'({busy, done, singular, ovf, err}), 64'(0));
        void'(sb.pop_back());
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        int sz;
        int mode;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("reset_state", 64'(state_q), 64'(6'b000001));
        check("reset_det", 64'(det), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_flags", 64'({singular, ovf, err}), 64'(0));
        @(posedge Clk); #1;

        set_identity(8);
        run_op(8, 1'b0);

        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                matv[r][c] = 15;
        run_op(8, 1'b0);

        fill_rand(15);
        matv[0][0] = 0; matv[0][1] = 1;
        matv[1][0] = 1; matv[1][1] = 0;
        run_op(2, 1'b0);

        fill_rand(15);
        matv[0][0] = 2; matv[0][1] = 1; matv[0][2] = 1;
        matv[1][0] = 1; matv[1][1] = 3; matv[1][2] = 2;
        matv[2][0] = 1; matv[2][1] = 0; matv[2][2] = 0;
        run_op(3, 1'b0);
        run_op(9, 1'b0);
        run_op(0, 1'b0);

        set_identity(3);
        run_op(3, 1'b1);

        reset_in_div();
        set_identity(4);
        run_op(4, 1'b0);

        for (int n = 0; n < 16; n++) begin
            sz   = (n == 15) ? 7 : int'($urandom_range(1, 6));
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                fill_rand(15);
            end else if (mode == 1) begin
                fill_rand(1);
            end else begin
                fill_rand(3);
                if (sz > 1) begin
                    for (int c = 0; c < 8; c++) matv[sz-1][c] = matv[0][c];
                end
            end
            run_op(sz, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/det_nxn.md
DET_NXN -- requirements
Module: det_nxn

Interface
REQ-001 SHALL have parameter N, default 8, meaning maximum matrix dimension (2..8).
REQ-002 SHALL have parameter EW, default 4, meaning element width in bits.
REQ-003 SHALL have parameter DW, default 48, meaning signed determinant and working-element width.
REQ-004 SHALL have port Clk  in  1  clock, with all state updated on its rising edge.
REQ-005 SHALL have port Reset  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port Start  in  1  request, sampled only in IDLE.
REQ-007 SHALL have port Ack  in  1  result acknowledge, sampled only in DONE.
REQ-008 SHALL have port size  in  4  active dimension, latched with Start.
REQ-009 SHALL have port mat_flat  in  N*N*EW  matrix, with element (r,c) at bits [(r*N+c)*EW +: EW], row-major, stride N regardless of size.
REQ-010 SHALL have port det  out  DW  signed determinant, valid while done=1.
REQ-011 SHALL have port busy  out  1  high from the cycle after an accepted Start until entry to DONE.
REQ-012 SHALL have port done  out  1  high in DONE.
REQ-013 SHALL have ports singular, ovf, err  out  1 each  status flags.
REQ-014 SHALL have port state_q  out  6  one-hot state {DONE,DIV,ELIM,PIVOT,LOAD,IDLE}, MSB first.

Function
REQ-015 SHALL compute the determinant of the top-left size x size submatrix by fraction-free Bareiss elimination with row pivoting, giving an exact integer result.
REQ-016 SHALL latch size and all elements into a DW-bit signed working array in LOAD, taking one cycle; sign:=+1, prev:=1, k:=0.
REQ-017 SHALL, in IDLE on Start=1, go to LOAD; size=0 or size>N instead goes to DONE with err=1 and det=0.
REQ-018 SHALL, in PIVOT, go to ELIM when M[k][k]!=0; otherwise scan one row r>k per cycle, swap rows k and r in one cycle on the first nonzero M[r][k], and negate sign.
REQ-019 SHALL, when no pivot row exists, go to DONE with singular=1 and det=0.
REQ-020 SHALL, in ELIM, process one (i,j) pair per cycle for i,j in k+1..size-1, computing num = M[k][k]*M[i][j] - M[i][k]*M[k][j] at 2*DW bits.
REQ-021 SHALL, in ELIM, divide num by prev: when k=0 write num directly; otherwise go to DIV, start the divider, and write the quotient on divider done.
REQ-022 SHALL, after the last pair, set prev:=M[k][k] and k:=k+1; when k reaches size-1, det:=sign*M[size-1][size-1] and the state goes to DONE, otherwise to PIVOT.
REQ-023 SHALL handle size=1 with det=M[0][0] and no PIVOT or ELIM states.
REQ-024 SHALL set ovf (sticky until next Start) when any written element or det is not representable in DW signed bits, with the result still delivered truncated.
REQ-025 SHALL hold DONE and det until Ack=1, then go to IDLE on the next edge.
REQ-026 SHALL ignore Start outside IDLE; Start and Ack together in DONE give IDLE only.
REQ-027 SHALL clear singular, ovf and err on an accepted Start.

Reset
REQ-028 SHALL, on Reset, immediately force state IDLE, det=0, busy=done=singular=ovf=err=0, abort any divide, and leave the working array don't-care.
REQ-029 SHALL, when Reset is asserted mid-operation, resume normal operation on the first Start after deassertion.

Configuration
REQ-030 SHALL interpret elements as two's-complement EW-bit values, sign-extended to DW, when DETN_SIGNED_EN is defined.
REQ-031 SHALL interpret elements as unsigned, zero-extended to DW, when DETN_SIGNED_EN is undefined.

Structure
REQ-032 SHALL place the state encoding localparams, default N/EW/DW, and the flat-index helper function in shared package det_pkg.
REQ-033 SHALL implement the divide in sub-module det_sdiv: a signed restoring divider, 2*DW-bit dividend and DW-bit divisor, one quotient bit per cycle, start/done handshake, 2*DW+1 cycles.

Verification
REQ-034 SHALL pass: size=8, identity -> det=1, singular=0, ovf=0.
REQ-035 SHALL pass: size=8, all elements 15 -> det=0, singular=1.
REQ-036 SHALL pass: size=2, [[0,1],[1,0]] -> one swap, det=-1 (0xFFFF_FFFF_FFFF at DW=48).
REQ-037 SHALL pass: size=3, [[2,1,1],[1,3,2],[1,0,0]] -> det=-1; same with size=9 -> err=1, det=0.
REQ-038 SHALL pass: Reset pulse during DIV -> state_q=000001 and all outputs 0 within the same cycle; next Start on identity -> det=1.
REQ-039 SHALL pass: Start pulsed while busy -> ignored; done held 20 cycles with Ack=0 -> det stable; Ack=1 -> IDLE next edge.
